vector_lane_engine: RTL

//   Parametrised multi-lane vector execution engine; successor to the fixed 2-lane vector function unit.

---
 rtl/vector_lane_engine_pkg.sv | 31 +++
 rtl/vector_lane_engine_if.sv | 34 +++
 rtl/vector_lane_engine_alu.sv | 51 +++++
 rtl/vector_lane_engine.sv | 115 +++++++++++
 4 files changed

// File: rtl/vector_lane_engine_pkg.sv
// vector_lane_engine_pkg: op/operand-form/state codes shared by the vector lane engine
package vector_lane_engine_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_RSUB = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_MINU = 4'd6;
    localparam logic [3:0] OP_MIN  = 4'd7;
    localparam logic [3:0] OP_MAXU = 4'd8;
    localparam logic [3:0] OP_MAX  = 4'd9;
    localparam logic [3:0] OP_SLL  = 4'd10;
    localparam logic [3:0] OP_SRL  = 4'd11;
    localparam logic [3:0] OP_SRA  = 4'd12;

    localparam logic [1:0] SRC_VV = 2'd0;
    localparam logic [1:0] SRC_VX = 2'd1;
    localparam logic [1:0] SRC_VI = 2'd2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Codes above SRA are unassigned and make the op a no-op
    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_SRA;
    endfunction

endpackage

// File: rtl/vector_lane_engine_if.sv
// vector_lane_engine_if: request/response handshake bundle of the vector lane engine
interface vector_lane_engine_if #(
    parameter int VLEN = 256,
    parameter int ELEN = 64,
    parameter int VLW  = $clog2(VLEN / 8) + 1
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [1:0]        req_src;
    logic [1:0]        req_sew;
    logic [VLW-1:0]    req_vl;
    logic              req_vm;
    logic [VLEN-1:0]   req_vs1;
    logic [VLEN-1:0]   req_vs2;
    logic [VLEN-1:0]   req_vd_old;
    logic [VLEN/8-1:0] req_mask;
    logic [ELEN-1:0]   req_scalar;
    logic              resp_valid;
    logic              resp_ready;
    logic [VLEN-1:0]   resp_vd;

    modport master (
        output req_valid, req_op, req_src, req_sew, req_vl, req_vm, req_vs1, req_vs2,
               req_vd_old, req_mask, req_scalar, resp_ready,
        input  req_ready, resp_valid, resp_vd
    );

    modport slave (
        input  req_valid, req_op, req_src, req_sew, req_vl, req_vm, req_vs1, req_vs2,
               req_vd_old, req_mask, req_scalar, resp_ready,
        output req_ready, resp_valid, resp_vd
    );
endinterface

// File: rtl/vector_lane_engine_alu.sv
// vector_lane_engine_alu: one-element combinational ALU, result truncated to SEW
module vector_lane_engine_alu
    import vector_lane_engine_pkg::*;
#(
    parameter int ELEN = 64
) (
    input  logic [1:0]      i_sew,
    input  logic [3:0]      i_op,
    input  logic [ELEN-1:0] i_a,
    input  logic [ELEN-1:0] i_b,
    output logic [ELEN-1:0] o_y
);
    localparam int SHW = $clog2(ELEN);

    logic [31:0]     w_w;
    logic [31:0]     w_sh;
    logic [ELEN-1:0] w_sa, w_sb, w_za, w_zb, w_mask, w_r;
    logic [SHW-1:0]  w_amt;

    // Operands are re-extended from SEW so compares and right shifts see the element, not stale upper bits
    assign w_w    = 32'd8 << i_sew;
    assign w_sh   = 32'(ELEN) - w_w;
    assign w_sa   = $signed(i_a << w_sh) >>> w_sh;
    assign w_sb   = $signed(i_b << w_sh) >>> w_sh;
    assign w_za   = (i_a << w_sh) >> w_sh;
    assign w_zb   = (i_b << w_sh) >> w_sh;
    assign w_mask = {ELEN{1'b1}} >> w_sh;
    assign w_amt  = i_b[SHW-1:0] & SHW'(w_w - 32'd1);
    assign o_y    = w_r & w_mask;

    // Element operation at full ELEN width; the SEW mask above makes it modulo 2^SEW
    always_comb begin
        w_r = '0;
        case (i_op)
            OP_ADD:  w_r = i_a + i_b;
            OP_SUB:  w_r = i_a - i_b;
            OP_RSUB: w_r = i_b - i_a;
            OP_AND:  w_r = i_a & i_b;
            OP_OR:   w_r = i_a | i_b;
            OP_XOR:  w_r = i_a ^ i_b;
            OP_MINU: w_r = w_za < w_zb ? i_a : i_b;
            OP_MIN:  w_r = $signed(w_sa) < $signed(w_sb) ? i_a : i_b;
            OP_MAXU: w_r = w_za > w_zb ? i_a : i_b;
            OP_MAX:  w_r = $signed(w_sa) > $signed(w_sb) ? i_a : i_b;
            OP_SLL:  w_r = i_a << w_amt;
            OP_SRL:  w_r = w_za >> w_amt;
            OP_SRA:  w_r = $signed(w_sa) >>> w_amt;
            default: w_r = '0;
        endcase
    end
endmodule

// File: rtl/vector_lane_engine.sv
// vector_lane_engine: sweeps a whole-register vector op LANES elements per cycle with mask/tail-undisturbed merge
module vector_lane_engine
    import vector_lane_engine_pkg::*;
#(
    parameter int VLEN  = 256,
    parameter int ELEN  = 64,
    parameter int LANES = 4,
    parameter int VLW   = $clog2(VLEN / 8) + 1
) (
    input  logic                clk,
    input  logic                rst,
    vector_lane_engine_if.slave bus,
    output logic                o_busy
);
    localparam int NE = VLEN / 8;
    localparam int BW = $clog2((NE + LANES) * ELEN) + 1;

    logic [1:0]      r_state;
    logic [VLW-1:0]  r_idx, r_vl;
    logic [3:0]      r_op;
    logic [1:0]      r_src, r_sew;
    logic            r_vm;
    logic [VLEN-1:0] r_vs1, r_vs2, r_buf;
    logic [NE-1:0]   r_mask;
    logic [ELEN-1:0] r_scalar;

    logic            w_acc, w_legal, w_last;
    logic [VLW-1:0]  w_maxe, w_vl_eff;
    logic [ELEN-1:0] w_imm, w_emask;
    logic [VLEN-1:0] w_wm [LANES];
    logic [VLEN-1:0] w_wd [LANES];
    logic [VLEN-1:0] w_wmask, w_wdata;

    assign bus.req_ready  = rst && r_state == S_IDLE;
    assign bus.resp_valid = r_state == S_DONE;
    assign bus.resp_vd    = r_buf;
    assign o_busy         = r_state != S_IDLE;

    // Illegal op/SEW collapses to vl=0 so the response is just vd_old
    assign w_acc    = bus.req_valid && rst && r_state == S_IDLE;
    assign w_maxe   = VLW'(NE) >> bus.req_sew;
    assign w_legal  = op_legal(bus.req_op) && ((32'd8 << bus.req_sew) <= 32'(ELEN));
    assign w_vl_eff = !w_legal ? '0 : (bus.req_vl < w_maxe ? bus.req_vl : w_maxe);
    assign w_imm    = {{(ELEN - 5){r_scalar[4]}}, r_scalar[4:0]};
    assign w_emask  = ~({ELEN{1'b1}} << (32'd8 << r_sew));
    assign w_last   = ({1'b0, r_idx} + (VLW + 1)'(LANES)) >= {1'b0, r_vl};

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [VLW:0]    w_e;
        logic [BW-1:0]   w_off;
        logic [ELEN-1:0] w_a, w_b, w_y;
        logic [NE-1:0]   w_msh;
        logic            w_en;
        assign w_e   = {1'b0, r_idx} + (VLW + 1)'(j);
        assign w_off = BW'(w_e) << ({1'b0, r_sew} + 3'd3);
        assign w_a   = ELEN'(r_vs2 >> w_off);
        assign w_b   = r_src == SRC_VV ? ELEN'(r_vs1 >> w_off) : r_src == SRC_VX ? r_scalar : w_imm;
        assign w_msh = r_mask >> w_e;
        assign w_en  = (w_e < {1'b0, r_vl}) && (r_vm || w_msh[0]);
        vector_lane_engine_alu #(.ELEN(ELEN)) u_alu (
            .i_sew (r_sew),
            .i_op  (r_op),
            .i_a   (w_a),
            .i_b   (w_b),
            .o_y   (w_y)
        );
        assign w_wm[j] = w_en ? (VLEN'(w_emask) << w_off) : '0;
        assign w_wd[j] = w_en ? (VLEN'(w_y) << w_off) : '0;
    end

    // Merge every lane's element write-enable and data into one register-wide update
    always_comb begin
        w_wmask = '0;
        w_wdata = '0;
        for (int k = 0; k < LANES; k++) begin
            w_wmask |= w_wm[k];
            w_wdata |= w_wd[k];
        end
    end

    // FSM, element index and result buffer (preloaded with vd_old so skipped elements stay undisturbed)
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_vl    <= '0;
            r_buf   <= '0;
        end else if (w_acc) begin
            r_state <= w_vl_eff == '0 ? S_DONE : S_RUN;
            r_idx   <= '0;
            r_vl    <= w_vl_eff;
            r_buf   <= bus.req_vd_old;
        end else if (r_state == S_RUN) begin
            r_buf   <= (r_buf & ~w_wmask) | w_wdata;
            r_idx   <= r_idx + VLW'(LANES);
            r_state <= w_last ? S_DONE : S_RUN;
        end else if (r_state == S_DONE && bus.resp_ready) begin
            r_state <= S_IDLE;
        end
    end

    // Operand capture on accept; held for the whole sweep
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_op     <= bus.req_op;
            r_src    <= bus.req_src;
            r_sew    <= bus.req_sew;
            r_vm     <= bus.req_vm;
            r_vs1    <= bus.req_vs1;
            r_vs2    <= bus.req_vs2;
            r_mask   <= bus.req_mask;
            r_scalar <= bus.req_scalar;
        end
    end
endmodule
